// File: rtl/wb_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jay_pkg
//  Purpose  : Shared types and register indices for the writeback/load block.
//  Revision : 1.0  initial release
// ============================================================================
package jay_pkg;

  typedef enum logic [0:0] {IDLE, LD_WAIT} wb_state_t;

  localparam logic [2:0] R_ZERO = 3'd0;
  localparam logic [2:0] R_ONE  = 3'd1;
  localparam logic [2:0] R_LOAD = 3'd2;

endpackage
`default_nettype wire

// File: rtl/wb_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_load_ctrl_if
//  Purpose  : Execute, data-memory and register-file signals of the controller.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_load_ctrl_if #(
  parameter int DW  = 8,
  parameter int RAW = 3,
  parameter int MAW = 8
);
  logic           in_valid;
  logic           in_ld;
  logic           in_wr;
  logic [RAW-1:0] in_dest;
  logic [DW-1:0]  in_result;
  logic [MAW-1:0] in_ld_addr;
  logic           stall;
  logic           mem_rd_req;
  logic [MAW-1:0] mem_addr;
  logic           mem_rd_valid;
  logic [DW-1:0]  mem_rd_data;
  logic [DW-1:0]  rf_dat_in;
  logic           rf_wr_en;
  logic           rf_mem_to_reg;
  logic [RAW-1:0] rf_wr_addr;
  logic           ld_err;

  // Environment side: execute stage, data memory and register-file observer.
  modport master (
    output in_valid, in_ld, in_wr, in_dest, in_result, in_ld_addr,
    output mem_rd_valid, mem_rd_data,
    input  stall, mem_rd_req, mem_addr,
    input  rf_dat_in, rf_wr_en, rf_mem_to_reg, rf_wr_addr, ld_err
  );

  modport slave (
    input  in_valid, in_ld, in_wr, in_dest, in_result, in_ld_addr,
    input  mem_rd_valid, mem_rd_data,
    output stall, mem_rd_req, mem_addr,
    output rf_dat_in, rf_wr_en, rf_mem_to_reg, rf_wr_addr, ld_err
  );
endinterface
`default_nettype wire

// File: rtl/wb_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wb_load_ctrl
//  Purpose  : Register-file writeback for ALU results and data-memory loads.
//  Revision : 1.0  initial release
// ============================================================================
module wb_load_ctrl
  import jay_pkg::*;
#(
  parameter int          DW      = 8,
  parameter int          RAW     = 3,
  parameter int          MAW     = 8,
  parameter int          TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_DAT = 8'hFF
) (
  input  wire logic     clk,
  input  wire logic     reset,
  wb_load_ctrl_if.slave bus
);

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  wb_state_t      r_state;
  logic [7:0]     r_cnt;
  logic           r_mem_rd_req;
  logic [MAW-1:0] r_mem_addr;
  logic [DW-1:0]  r_rf_dat_in;
  logic           r_rf_wr_en;
  logic           r_rf_mem_to_reg;
  logic [RAW-1:0] r_rf_wr_addr;
  logic           r_ld_err;

  logic w_accept;
  logic w_hardwired;

  assign bus.stall   = (r_state != IDLE);
  assign w_accept    = bus.in_valid & ~bus.stall;
  assign w_hardwired = (bus.in_dest == RAW'(R_ZERO)) || (bus.in_dest == RAW'(R_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_mem_rd_req    <= 1'b0;
      r_mem_addr      <= '0;
      r_rf_dat_in     <= '0;
      r_rf_wr_en      <= 1'b0;
      r_rf_mem_to_reg <= 1'b0;
      r_rf_wr_addr    <= '0;
      r_ld_err        <= 1'b0;
    end else begin
      r_rf_wr_en      <= 1'b0;
      r_rf_mem_to_reg <= 1'b0;
      r_ld_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.in_ld) begin
              r_state      <= LD_WAIT;
              r_mem_rd_req <= 1'b1;
              r_mem_addr   <= bus.in_ld_addr;
              r_cnt        <= '0;
            end else if (bus.in_wr && !w_hardwired) begin
              r_rf_wr_en   <= 1'b1;
              r_rf_wr_addr <= bus.in_dest;
              r_rf_dat_in  <= bus.in_result;
            end
          end
        end
        LD_WAIT: begin
          // Returned data takes priority over a timeout expiring in the same cycle.
          if (bus.mem_rd_valid) begin
            r_state         <= IDLE;
            r_mem_rd_req    <= 1'b0;
            r_rf_mem_to_reg <= 1'b1;
            r_rf_wr_addr    <= RAW'(R_LOAD);
            r_rf_dat_in     <= bus.mem_rd_data;
          end else if (r_cnt == c_TMO_LAST) begin
            r_state         <= IDLE;
            r_mem_rd_req    <= 1'b0;
            r_rf_mem_to_reg <= 1'b1;
            r_rf_wr_addr    <= RAW'(R_LOAD);
            r_rf_dat_in     <= ERR_DAT;
            r_ld_err        <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_req    = r_mem_rd_req;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.rf_dat_in     = r_rf_dat_in;
  assign bus.rf_wr_en      = r_rf_wr_en;
  assign bus.rf_mem_to_reg = r_rf_mem_to_reg;
  assign bus.rf_wr_addr    = r_rf_wr_addr;
  assign bus.ld_err        = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_load_ctrl
//  Purpose  : Directed checks of ALU writeback, loads, timeout and reset abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_load_ctrl;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  wb_load_ctrl_if #(.DW(8), .RAW(3), .MAW(8)) bus ();

  wb_load_ctrl #(
    .DW(8), .RAW(3), .MAW(8), .TIMEOUT(16), .ERR_DAT(8'hFF)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0; bus.in_ld = 1'b0; bus.in_wr = 1'b0;
    bus.in_dest = '0; bus.in_result = '0; bus.in_ld_addr = '0;
  endtask

  task automatic alu(input logic [2:0] dest, input logic [7:0] res, input logic wr);
    bus.in_valid = 1'b1; bus.in_ld = 1'b0; bus.in_wr = wr;
    bus.in_dest = dest; bus.in_result = res;
  endtask

  task automatic load(input logic [7:0] addr);
    bus.in_valid = 1'b1; bus.in_ld = 1'b1; bus.in_wr = 1'b0; bus.in_ld_addr = addr;
  endtask

  int req_cycles;

  initial begin
    n_total = 0; n_bad = 0;
    idle_in();
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    reset = 1'b1;
    step(); step();
    chk("rst_wr_en",  bus.rf_wr_en, 0);
    chk("rst_m2r",    bus.rf_mem_to_reg, 0);
    chk("rst_req",    bus.mem_rd_req, 0);
    chk("rst_stall",  bus.stall, 0);
    chk("rst_lderr",  bus.ld_err, 0);
    chk("rst_dat",    bus.rf_dat_in, 0);
    reset = 1'b0;
    step();

    // 1: plain ALU write
    alu(3'd5, 8'h3C, 1'b1);
    chk("t1_stall0", bus.stall, 0);
    step();
    idle_in();
    chk("t1_wr_en", bus.rf_wr_en, 1);
    chk("t1_addr",  bus.rf_wr_addr, 5);
    chk("t1_dat",   bus.rf_dat_in, 8'h3C);
    chk("t1_m2r",   bus.rf_mem_to_reg, 0);
    chk("t1_stall1", bus.stall, 0);
    step();
    chk("t1_pulse", bus.rf_wr_en, 0);

    // 2: hardwired destinations and in_wr=0
    alu(3'd0, 8'h11, 1'b1); step();
    chk("t2_r0", bus.rf_wr_en, 0);
    alu(3'd1, 8'h22, 1'b1); step();
    chk("t2_r1", bus.rf_wr_en, 0);
    alu(3'd4, 8'h33, 1'b0); step();
    chk("t2_nowr", bus.rf_wr_en, 0);
    idle_in();

    // mem_rd_valid while idle is ignored
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'hEE;
    step();
    chk("idle_valid", bus.rf_mem_to_reg, 0);
    bus.mem_rd_valid = 1'b0;

    // 3: load returning on its third wait cycle
    load(8'h40);
    step();
    idle_in();
    chk("t3_addr",  bus.mem_addr, 8'h40);
    chk("t3_stall", bus.stall, 1);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_rd_req) req_cycles++;
      if (i == 2) begin bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'hA5; end
      step();
    end
    bus.mem_rd_valid = 1'b0;
    chk("t3_reqcyc", req_cycles, 3);
    chk("t3_req0",  bus.mem_rd_req, 0);
    chk("t3_m2r",   bus.rf_mem_to_reg, 1);
    chk("t3_dat",   bus.rf_dat_in, 8'hA5);
    chk("t3_waddr", bus.rf_wr_addr, 2);
    chk("t3_wr_en", bus.rf_wr_en, 0);
    chk("t3_stall", bus.stall, 0);
    step();
    chk("t3_pulse", bus.rf_mem_to_reg, 0);

    // 4a: timeout with no response
    load(8'h55);
    step();
    idle_in();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_stall%0d", i), bus.stall, 1);
      step();
    end
    chk("t4_m2r",   bus.rf_mem_to_reg, 1);
    chk("t4_dat",   bus.rf_dat_in, 8'hFF);
    chk("t4_err",   bus.ld_err, 1);
    chk("t4_req0",  bus.mem_rd_req, 0);
    chk("t4_stall", bus.stall, 0);
    step();
    chk("t4_errp",  bus.ld_err, 0);
    chk("t4_m2rp",  bus.rf_mem_to_reg, 0);

    // 4b: valid on the timeout cycle wins
    load(8'h56);
    step();
    idle_in();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'h5A; end
      step();
    end
    bus.mem_rd_valid = 1'b0;
    chk("t4b_m2r", bus.rf_mem_to_reg, 1);
    chk("t4b_dat", bus.rf_dat_in, 8'h5A);
    chk("t4b_err", bus.ld_err, 0);
    step();

    // 5: ALU op accepted in the load writeback cycle
    load(8'h60);
    step();
    idle_in();
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'h77;
    step();
    bus.mem_rd_valid = 1'b0;
    chk("t5_m2r", bus.rf_mem_to_reg, 1);
    chk("t5_dat", bus.rf_dat_in, 8'h77);
    alu(3'd3, 8'h9E, 1'b1);
    step();
    idle_in();
    chk("t5_wr_en", bus.rf_wr_en, 1);
    chk("t5_m2r0",  bus.rf_mem_to_reg, 0);
    chk("t5_addr",  bus.rf_wr_addr, 3);
    chk("t5_dat2",  bus.rf_dat_in, 8'h9E);

    // back-to-back loads: second accepted in the first one's writeback cycle
    load(8'h70);
    step();
    idle_in();
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'h12;
    step();
    bus.mem_rd_valid = 1'b0;
    chk("bb_m2r", bus.rf_mem_to_reg, 1);
    load(8'h50);
    step();
    idle_in();
    chk("bb_req",  bus.mem_rd_req, 1);
    chk("bb_addr", bus.mem_addr, 8'h50);

    // 6: asynchronous reset mid-LD_WAIT
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req",   bus.mem_rd_req, 0);
    chk("t6_addr",  bus.mem_addr, 0);
    chk("t6_stall", bus.stall, 0);
    chk("t6_dat",   bus.rf_dat_in, 0);
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 8'h99;
    step();
    reset = 1'b0;
    step();
    chk("t6_late_m2r", bus.rf_mem_to_reg, 0);
    bus.mem_rd_valid = 1'b0;
    step();
    chk("t6_late_m2r2", bus.rf_mem_to_reg, 0);
    chk("t6_late_wr",   bus.rf_wr_en, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
